// File: rtl/run_host_pkg.sv
// ------------------------------------------------------------------
// host_pkg: shared state encoding and default timing constants.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CRST  = 3'd1,
    ST_REQ   = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAULT = 3'd6
  } host_state_t;

  localparam int unsigned DEF_RST_CYC    = 2;
  localparam int unsigned DEF_MAX_CYCLES = 4095;

endpackage

`default_nettype wire

// File: rtl/run_host_if.sv
// ------------------------------------------------------------------
// run_host_if: core handshake, debug read port and result stream.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface run_host_if #(
  parameter int CW = 16
) ();

  logic          start;
  logic          core_reset;
  logic          core_req;
  logic          core_done;
  logic [7:0]    mem_addr;
  logic [7:0]    mem_dat;
  logic          res_valid;
  logic [7:0]    res_data;
  logic          res_ready;
  logic          busy;
  logic          timeout;
  logic [CW-1:0] cycles;
  logic          finished;

  modport master (
    input  start, core_done, mem_dat, res_ready,
    output core_reset, core_req, mem_addr, res_valid, res_data,
           busy, timeout, cycles, finished
  );

  modport slave (
    output start, core_done, mem_dat, res_ready,
    input  core_reset, core_req, mem_addr, res_valid, res_data,
           busy, timeout, cycles, finished
  );

endinterface

`default_nettype wire

// File: rtl/run_host_sat_counter.sv
// ------------------------------------------------------------------
// sat_counter: W-bit up counter with clear/enable, stops at LIMIT.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int          W     = 16,
  parameter int unsigned LIMIT = 4095
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         clr_i,
  input  wire logic         en_i,
  output logic [W-1:0]      count_o,
  output logic              last_o
);

  localparam logic [W-1:0] LIM    = W'(LIMIT);
  localparam logic [W-1:0] LIM_M1 = W'(LIMIT - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LIM)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // One more enabled cycle reaches the limit.
  assign last_o  = (count_q == LIM_M1);

endmodule

`default_nettype wire

// File: rtl/run_host.sv
// ------------------------------------------------------------------
// run_host: resets and runs the core, times it, streams back memory.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module run_host
  import host_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int          CW         = 16,
  parameter int unsigned RD_BASE    = 0,
  parameter int unsigned RD_LEN     = 8,
  parameter int unsigned RST_CYC    = DEF_RST_CYC
) (
  input  wire logic   clk,
  input  wire logic   reset,
  run_host_if.master  bus
);

  localparam int          RCW     = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RCW-1:0] RC_LAST = RCW'(RST_CYC - 1);
  localparam logic [8:0]  LEN     = 9'(RD_LEN);
  localparam logic [7:0]  BASE8   = 8'(RD_BASE);

  host_state_t    state_q, state_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic [8:0]     idx_q, idx_d;
  logic           core_reset_q, core_reset_d;
  logic           core_req_q, core_req_d;
  logic           res_valid_q, res_valid_d;
  logic [7:0]     res_data_q, res_data_d;
  logic           busy_q, busy_d;
  logic           timeout_q, timeout_d;
  logic           finished_q, finished_d;
  logic           start_run, cnt_en, cnt_last;
  logic [CW-1:0]  cnt;

  sat_counter #(
    .W     (CW),
    .LIMIT (MAX_CYCLES)
  ) u_cycles (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (start_run),
    .en_i    (cnt_en),
    .count_o (cnt),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    idx_d       = idx_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    timeout_d   = timeout_q;
    finished_d  = 1'b0;
    start_run   = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (bus.start) begin
          start_run = 1'b1;
          state_d   = ST_CRST;
          rcnt_d    = '0;
          idx_d     = '0;
          timeout_d = 1'b0;
        end
      end
      ST_CRST: begin
        if (rcnt_q == RC_LAST) begin
          state_d = ST_REQ;
        end else begin
          rcnt_d = rcnt_q + RCW'(1);
        end
      end
      ST_REQ: state_d = ST_RUN;
      ST_RUN: begin
        if (bus.core_done) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_en = 1'b1;
          if (cnt_last) begin
            state_d   = ST_FAULT;
            timeout_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Output register is free when empty or being emptied this cycle.
        if (res_valid_q && bus.res_ready && (idx_q == LEN)) begin
          res_valid_d = 1'b0;
          finished_d  = 1'b1;
          state_d     = ST_DONE;
        end else if ((!res_valid_q || bus.res_ready) && (idx_q < LEN)) begin
          res_data_d  = bus.mem_dat;
          res_valid_d = 1'b1;
          idx_d       = idx_q + 9'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    core_reset_d = (state_d == ST_CRST);
    core_req_d   = (state_d == ST_REQ);
    busy_d       = !(state_d inside {ST_IDLE, ST_DONE, ST_FAULT});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rcnt_q       <= '0;
      idx_q        <= '0;
      core_reset_q <= 1'b1;
      core_req_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      finished_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      idx_q        <= idx_d;
      core_reset_q <= core_reset_d;
      core_req_q   <= core_req_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      finished_q   <= finished_d;
    end
  end

  assign bus.mem_addr   = (state_q == ST_DRAIN) ? (BASE8 + idx_q[7:0]) : BASE8;
  assign bus.core_reset = core_reset_q;
  assign bus.core_req   = core_req_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.busy       = busy_q;
  assign bus.timeout    = timeout_q;
  assign bus.cycles     = cnt;
  assign bus.finished   = finished_q;

endmodule

`default_nettype wire

// File: tb/tb_run_host.sv
// ------------------------------------------------------------------
// tb_run_host: directed checks of run_host sequencing and streaming.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_run_host;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  run_host_if #(.CW(16)) m_if ();
  run_host_if #(.CW(16)) t_if ();
  run_host_if #(.CW(16)) w_if ();

  run_host #(.MAX_CYCLES(4095)) u_main (.clk(clk), .reset(reset), .bus(m_if));
  run_host #(.MAX_CYCLES(50))   u_to   (.clk(clk), .reset(reset), .bus(t_if));
  run_host #(.RD_BASE(254), .RD_LEN(4)) u_wrap (.clk(clk), .reset(reset), .bus(w_if));

  // Memory holds (address + 0x10) mod 256.
  logic [7:0] mem [256];
  assign m_if.mem_dat = mem[m_if.mem_addr];
  assign t_if.mem_dat = mem[t_if.mem_addr];
  assign w_if.mem_dat = mem[w_if.mem_addr];

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    int done_k;
    bit bp;
    int exp_cycles;
    int exp_bytes;
  } run_vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main_reset(input string pfx);
    chk({pfx, "_core_reset"}, 32'(m_if.core_reset), 32'd1);
    chk({pfx, "_core_req"},   32'(m_if.core_req),   32'd0);
    chk({pfx, "_res_valid"},  32'(m_if.res_valid),  32'd0);
    chk({pfx, "_res_data"},   32'(m_if.res_data),   32'd0);
    chk({pfx, "_mem_addr"},   32'(m_if.mem_addr),   32'd0);
    chk({pfx, "_busy"},       32'(m_if.busy),       32'd0);
    chk({pfx, "_timeout"},    32'(m_if.timeout),    32'd0);
    chk({pfx, "_cycles"},     32'(m_if.cycles),     32'd0);
    chk({pfx, "_finished"},   32'(m_if.finished),   32'd0);
  endtask

  task automatic main_run(input run_vec_t v);
    int       nacc;
    int       cyc;
    bit       stalled;
    logic [7:0] held;
    m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    chk("crst_1",      32'(m_if.core_reset), 32'd1);
    chk("crst_busy",   32'(m_if.busy),       32'd1);
    chk("crst_cycles", 32'(m_if.cycles),     32'd0);
    tick();
    chk("crst_2",      32'(m_if.core_reset), 32'd1);
    chk("crst_noreq",  32'(m_if.core_req),   32'd0);
    tick();
    chk("crst_end",    32'(m_if.core_reset), 32'd0);
    chk("req_on",      32'(m_if.core_req),   32'd1);
    tick();
    chk("req_off",     32'(m_if.core_req),   32'd0);
    repeat (v.done_k) tick();
    m_if.core_done = 1'b1;
    tick();
    m_if.core_done = 1'b0;
    chk("run_cycles", 32'(m_if.cycles), 32'(v.exp_cycles));
    nacc = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (!m_if.finished && cyc < 100) begin
      m_if.res_ready = v.bp ? cyc[0] : 1'b1;
      if (stalled) chk("stall_hold", {23'd0, m_if.res_valid, m_if.res_data}, {23'd0, 1'b1, held});
      if (m_if.res_valid && m_if.res_ready) begin
        chk("byte", 32'(m_if.res_data), 32'(8'h10 + nacc[7:0]));
        nacc++;
      end
      stalled = m_if.res_valid && !m_if.res_ready;
      held = m_if.res_data;
      tick();
      cyc++;
    end
    chk("finished_seen", 32'(m_if.finished), 32'd1);
    chk("nbytes",        32'(nacc),          32'(v.exp_bytes));
    chk("done_busy",     32'(m_if.busy),      32'd0);
    chk("done_valid",    32'(m_if.res_valid), 32'd0);
    m_if.res_ready = 1'b0;
    tick();
    chk("fin_pulse",     32'(m_if.finished),  32'd0);
    chk("done_hold_cyc", 32'(m_if.cycles),    32'(v.exp_cycles));
  endtask

  run_vec_t vecs [4];
  logic [7:0] exp_addr [4];
  logic [7:0] exp_wdat [4];

  initial begin
    int cyc;
    bit sawv;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
    vecs[0] = '{done_k: 20, bp: 1'b0, exp_cycles: 20, exp_bytes: 8};
    vecs[1] = '{done_k: 20, bp: 1'b1, exp_cycles: 20, exp_bytes: 8};
    vecs[2] = '{done_k: 0,  bp: 1'b0, exp_cycles: 0,  exp_bytes: 8};
    vecs[3] = '{done_k: 5,  bp: 1'b1, exp_cycles: 5,  exp_bytes: 8};
    exp_addr = '{8'd254, 8'd255, 8'd0, 8'd1};
    exp_wdat = '{8'h0E, 8'h0F, 8'h10, 8'h11};

    {m_if.start, m_if.core_done, m_if.res_ready} = 3'b000;
    {t_if.start, t_if.core_done, t_if.res_ready} = 3'b000;
    {w_if.start, w_if.core_done, w_if.res_ready} = 3'b000;

    reset = 1'b1;
    repeat (3) tick();
    chk_main_reset("rst");
    reset = 1'b0;
    tick();
    chk("rst_release_core_reset", 32'(m_if.core_reset), 32'd0);

    for (int i = 0; i < 4; i++) main_run(vecs[i]);

    // Timeout with limit 50, then restart that completes immediately.
    t_if.start = 1'b1;
    tick();
    t_if.start = 1'b0;
    cyc = 0;
    sawv = 1'b0;
    while (t_if.busy && cyc < 200) begin
      if (t_if.res_valid) sawv = 1'b1;
      tick();
      cyc++;
    end
    chk("to_busy_len", 32'(cyc),           32'd53);
    chk("to_flag",     32'(t_if.timeout),  32'd1);
    chk("to_cycles",   32'(t_if.cycles),   32'd50);
    chk("to_novalid",  32'(sawv),          32'd0);
    chk("to_noreq",    32'(t_if.core_req), 32'd0);
    tick();
    chk("to_sticky",   32'(t_if.timeout),  32'd1);
    t_if.core_done = 1'b1;
    t_if.res_ready = 1'b1;
    t_if.start = 1'b1;
    tick();
    t_if.start = 1'b0;
    chk("to_clear",    32'(t_if.timeout),    32'd0);
    chk("to_restart",  32'(t_if.core_reset), 32'd1);
    cyc = 0;
    while (!t_if.finished && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("imm_finished", 32'(t_if.finished), 32'd1);
    chk("imm_cycles",   32'(t_if.cycles),   32'd0);
    t_if.core_done = 1'b0;

    // Read window wrapping past address 255.
    w_if.core_done = 1'b1;
    w_if.res_ready = 1'b1;
    w_if.start = 1'b1;
    tick();
    w_if.start = 1'b0;
    repeat (4) tick();
    for (int j = 0; j < 5; j++) begin
      if (j < 4) chk("wrap_addr", 32'(w_if.mem_addr), 32'(exp_addr[j]));
      if (j > 0) chk("wrap_data", 32'(w_if.res_data), 32'(exp_wdat[j-1]));
      tick();
    end
    chk("wrap_finished", 32'(w_if.finished), 32'd1);
    w_if.core_done = 1'b0;

    // Ignored start in RUN, then reset during DRAIN after 3 bytes.
    m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    repeat (3) tick();
    m_if.start = 1'b1;
    repeat (2) tick();
    m_if.start = 1'b0;
    chk("ign_no_reset", 32'(m_if.core_reset), 32'd0);
    chk("ign_busy",     32'(m_if.busy),       32'd1);
    m_if.core_done = 1'b1;
    tick();
    m_if.core_done = 1'b0;
    chk("ign_cycles", 32'(m_if.cycles), 32'd2);
    m_if.res_ready = 1'b1;
    repeat (4) tick();
    chk("mid_byte3", 32'(m_if.res_data), 32'h13);
    reset = 1'b1;
    tick();
    chk_main_reset("midrst");
    reset = 1'b0;
    m_if.res_ready = 1'b0;
    tick();
    chk("midrst_release", 32'(m_if.core_reset), 32'd0);
    chk("midrst_idle",    32'(m_if.busy),       32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/run_host.md
# run_host

Host-side sequencer that drives the processor core's `req`/`done` run handshake from the initiator end. On `start` it resets the core, pulses `req`, and counts cycles until `done` or a timeout. It then reads a fixed window of the core's data memory through a debug read port and streams the bytes out over a valid/ready interface. It sits between the testbench or system controller and the core top level.

## Interface
- `MAX_CYCLES`, 4095: timeout bound, in RUN cycles.
- `CW`, 16: width of the cycle counter; MAX_CYCLES < 2^CW.
- `RD_BASE`, 0: first data-memory address read back.
- `RD_LEN`, 8: number of bytes read back; 1..256.
- `RST_CYC`, 2: number of cycles `core_reset` is held per run.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request one run; sampled in IDLE, DONE or FAULT.
- `core_reset`  out  1  reset to the core.
- `core_req`  out  1  run request to the core.
- `core_done`  in  1  core completion level.
- `mem_addr`  out  8  debug read address into core data memory.
- `mem_dat`  in  8  combinational read data for `mem_addr`.
- `res_valid`  out  1  result byte valid.
- `res_data`  out  8  result byte.
- `res_ready`  in  1  consumer accepts the byte.
- `busy`  out  1  high in all states except IDLE, DONE and FAULT.
- `timeout`  out  1  sticky fault flag.
- `cycles`  out  CW  RUN-cycle count of the last run.
- `finished`  out  1  one-cycle pulse when the last byte is accepted.

## Operation
States: IDLE, CRST, REQ, RUN, DRAIN, DONE, FAULT.

- **IDLE.** `start` → CRST. Clears `cycles`, `timeout` and the byte index.
- **CRST.** Asserts `core_reset` for exactly RST_CYC cycles, then → REQ.
- **REQ.** Asserts `core_req` for one cycle, then → RUN.
- **RUN.**
  - Each cycle with `core_done`=0: `cycles`++.
  - `core_done`=1 → DRAIN; `cycles` freezes.
  - `core_done`=0 with `cycles`==MAX_CYCLES-1 → FAULT; `cycles`=MAX_CYCLES and `timeout`=1.
  - `core_done` is ignored outside RUN.
- **DRAIN.**
  - `mem_addr` = (RD_BASE + idx) mod 256.
  - Capture: when `res_valid`=0 or `res_ready`=1, and idx < RD_LEN, load `res_data` ← `mem_dat`, set `res_valid`=1, idx++.
  - The output register keeps `res_data` stable while `res_valid`=1 and `res_ready`=0.
  - When idx==RD_LEN and the last byte is accepted: `res_valid`←0, `finished` pulses, → DONE.
- **DONE.** `start` → CRST (new run). Otherwise holds `cycles`.
- **FAULT.** `core_req`=0, no streaming. `start` → CRST and clears `timeout`.
- `start` is ignored in CRST, REQ, RUN and DRAIN.
- The cycle counter never wraps. At MAX_CYCLES it saturates and the block faults.

## Timing
Reset values:
- state=IDLE
- `core_reset`=1: the core is held in reset while the host is in reset; it drops in the first cycle after `reset` deasserts.
- `core_req`=0, `res_valid`=0, `res_data`=0, `mem_addr`=RD_BASE, `busy`=0, `timeout`=0, `cycles`=0, `finished`=0.
- `reset` asserted mid-run aborts immediately to those values. Any byte in flight is dropped.

Latencies:
- `start` high in IDLE at cycle t → `core_reset`=1 at t+1..t+RST_CYC.
- `core_req`=1 at t+RST_CYC+1.
- RUN begins at t+RST_CYC+2.
- `core_done` seen at RUN cycle k (first RUN cycle = 0) → `cycles`=k and DRAIN is entered next cycle.
- First `res_valid` appears one cycle after DRAIN entry.
- With `res_ready` tied high: one byte per cycle. `finished` pulses in the cycle after the last byte's handshake.
- All outputs are registered except `mem_addr`, which is decoded from state and idx.

## Structure
- Package `host_pkg` holds:
  - the state enum `host_state_t`
  - the default constants for RST_CYC and MAX_CYCLES.
- One sub-module, `sat_counter`: a parameterised CW-bit counter with clear, enable and a saturate-at-limit flag. It is used for `cycles`. The RST_CYC counter and idx are local.

## Test plan
- **Normal run.** `start` pulse; `core_done` rises on RUN cycle 20; `res_ready`=1; memory[0..7]=0x10..0x17.
  Expect: `core_reset` 2 cycles, `core_req` 1 cycle, `cycles`=20, bytes 0x10..0x17 in order, `finished` once, state DONE.
- **Backpressure.** Same run, `res_ready` toggling 0/1.
  Expect: `res_data` stable while stalled, no byte lost or duplicated, 8 handshakes total.
- **Timeout.** MAX_CYCLES=50, `core_done` never asserted.
  Expect: `timeout`=1, `cycles`=50, no `res_valid`, FAULT. A following `start` clears `timeout` and restarts.
- **Immediate done.** `core_done` already 1 on the first RUN cycle.
  Expect: `cycles`=0.
- **Address wrap.** RD_BASE=254, RD_LEN=4.
  Expect: `mem_addr` sequence 254, 255, 0, 1.
- **Mid-run reset.** `reset` during DRAIN after 3 bytes.
  Expect: all outputs at reset values the next cycle, `core_reset`=1; ignored `start` during RUN causes no restart.
